// File: rtl/mips_cpu_harvard_bus_bridge.sv
// Bridge between the Harvard MIPS core and a single waitrequest-style memory bus.
// The core is held with clk_enable low while its fetch and optional data access
// are serialised onto the bus, then released for exactly one enabled cycle.
module mips_cpu_harvard_bus_bridge #(
    parameter int WAIT_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    output logic        cpu_clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [3:0]  bus_byteenable,
    output logic [31:0] bus_writedata,
    input  logic        bus_waitrequest,
    input  logic [31:0] bus_readdata,
    output logic        bus_error,
    output logic [31:0] instr_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_DREAD  = 3'd3;
    localparam logic [2:0] S_DWRITE = 3'd4;
    localparam logic [2:0] S_STEP   = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    // Last stalled cycle a transfer may see before it is declared hung.
    localparam logic [31:0] LIMIT_M1 = (WAIT_LIMIT > 0) ? 32'(WAIT_LIMIT - 1) : 32'd0;

    logic [2:0]  state;
    logic [2:0]  state_next;
    logic [31:0] wait_cnt;
    logic [31:0] wdata_q;
    logic        in_xfer;
    logic        timeout;

    assign in_xfer = (state == S_FETCH) || (state == S_DREAD) || (state == S_DWRITE);
    assign timeout = (WAIT_LIMIT != 0) && in_xfer && bus_waitrequest && (wait_cnt == LIMIT_M1);

    // Bus and core-facing outputs decode straight from state; the core keeps its
    // address/data inputs frozen while stalled, so they are stable under waitrequest.
    assign bus_read       = (state == S_FETCH) || (state == S_DREAD);
    assign bus_write      = (state == S_DWRITE);
    assign bus_byteenable = in_xfer ? 4'b1111 : 4'b0000;
    assign bus_writedata  = (state == S_DWRITE) ? wdata_q : 32'd0;
    assign cpu_clk_enable = (state == S_STEP);
    assign bus_error      = (state == S_ERROR);

    // Address mux: fetch uses the instruction port, data phases the data port.
    always_comb begin
        bus_address = 32'd0;
        if (state == S_FETCH)
            bus_address = instr_address;
        else if ((state == S_DREAD) || (state == S_DWRITE))
            bus_address = data_address;
    end

    // Next-state logic for the per-instruction sequence.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   state_next = cpu_active ? S_FETCH : S_HALT;
            S_FETCH: begin
                if (timeout)               state_next = S_ERROR;
                else if (!bus_waitrequest) state_next = S_SETTLE;
            end
            S_SETTLE: begin
                case ({data_read, data_write})
                    2'b10:   state_next = S_DREAD;
                    2'b01:   state_next = S_DWRITE;
                    2'b00:   state_next = S_STEP;
                    default: state_next = S_ERROR;
                endcase
            end
            S_DREAD, S_DWRITE: begin
                if (timeout)               state_next = S_ERROR;
                else if (!bus_waitrequest) state_next = S_STEP;
            end
            S_STEP:   state_next = S_IDLE;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_ERROR;
        endcase
    end

    // State, wait counter and latched data; reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            wait_cnt       <= 32'd0;
            wdata_q        <= 32'd0;
            instr_readdata <= 32'd0;
            data_readdata  <= 32'd0;
            instr_count    <= 32'd0;
        end else begin
            state <= state_next;
            if (in_xfer && bus_waitrequest)
                wait_cnt <= wait_cnt + 32'd1;
            else
                wait_cnt <= 32'd0;
            if ((state == S_FETCH) && !bus_waitrequest)
                instr_readdata <= bus_readdata;
            if ((state == S_DREAD) && !bus_waitrequest)
                data_readdata <= bus_readdata;
            if ((state == S_SETTLE) && data_write && !data_read)
                wdata_q <= data_writedata;
            if (state == S_STEP)
                instr_count <= instr_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_mips_cpu_harvard_bus_bridge.sv
// Scoreboard bench for the bus bridge: a tiny stand-in core plus a memory model
// with programmable wait states; expected bus transfers and CPU steps are queued
// by the stimulus and consumed by an independent monitor.
module tb_mips_cpu_harvard_bus_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_active, cpu_clk_enable;
    logic [31:0] instr_address, instr_readdata;
    logic [31:0] data_address, data_writedata, data_readdata;
    logic        data_read, data_write;
    logic [31:0] bus_address, bus_writedata, bus_readdata;
    logic        bus_read, bus_write, bus_waitrequest, bus_error;
    logic [3:0]  bus_byteenable;
    logic [31:0] instr_count;

    always #5 clk = ~clk;

    mips_cpu_harvard_bus_bridge #(.WAIT_LIMIT(8)) dut (
        .clk(clk), .reset(reset), .cpu_active(cpu_active), .cpu_clk_enable(cpu_clk_enable),
        .instr_address(instr_address), .instr_readdata(instr_readdata),
        .data_address(data_address), .data_read(data_read), .data_write(data_write),
        .data_writedata(data_writedata), .data_readdata(data_readdata),
        .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
        .bus_byteenable(bus_byteenable), .bus_writedata(bus_writedata),
        .bus_waitrequest(bus_waitrequest), .bus_readdata(bus_readdata),
        .bus_error(bus_error), .instr_count(instr_count)
    );

    // Stand-in core: decodes ADDIU/LW/SW with base $0, advances pc on each enabled cycle.
    logic [31:0] pc, pc_init, r2;
    logic        force_both = 1'b0;
    logic [5:0]  op;
    logic [31:0] simm;
    assign op             = instr_readdata[31:26];
    assign simm           = {{16{instr_readdata[15]}}, instr_readdata[15:0]};
    assign instr_address  = pc;
    assign cpu_active     = (pc < 32'd16);
    assign data_read      = force_both || (op == 6'h23);
    assign data_write     = force_both || (op == 6'h2B);
    assign data_address   = simm;
    assign data_writedata = r2;

    always @(posedge clk) begin
        if (!reset) pc <= pc_init;
        else if (cpu_clk_enable) begin
            pc <= pc + 32'd4;
            if (op == 6'h09 && instr_readdata[20:16] == 5'd2) r2 <= simm;
        end
    end

    // Memory: program ROM at 0x0..0xC, RAM above; wait_n stalls per transfer.
    logic [31:0] ram [0:255];
    logic [31:0] rom_w;
    int          wait_n = 0;
    int          wcnt = 0;
    logic        stuck = 1'b0, stuck_rd = 1'b0, ram_clr = 1'b1;

    always_comb begin
        rom_w = 32'd0;
        case (bus_address[3:2])
            2'd0: rom_w = 32'h2402_0005;  // ADDIU $2,$0,5
            2'd1: rom_w = 32'hAC02_0100;  // SW $2,0x100($0)
            2'd2: rom_w = 32'h8C03_0100;  // LW $3,0x100($0)
            default: rom_w = 32'h0000_0000;  // NOP
        endcase
    end
    assign bus_readdata    = (bus_address < 32'd16) ? rom_w : ram[bus_address[9:2]];
    assign bus_waitrequest = stuck || (stuck_rd && bus_read && bus_address == 32'h100) ||
                             ((bus_read || bus_write) && (wcnt < wait_n));

    always @(posedge clk) begin
        if (!reset || !(bus_read || bus_write) || !bus_waitrequest) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (!reset && ram_clr) ram[64] <= 32'hDEAD_BEEF;
        else if (reset && bus_write && !bus_waitrequest) ram[bus_address[9:2]] <= bus_writedata;
    end

    // Scoreboard
    typedef struct packed { logic [31:0] addr; logic wr; logic [31:0] data; logic [7:0] hold; } bus_t;
    typedef struct packed { logic [31:0] instr; logic [31:0] cnt; logic [31:0] dread; logic [7:0] gap; } step_t;
    bus_t  bus_q[$];
    step_t step_q[$];
    int    errors = 0, checks = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pb(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [7:0] h);
        bus_t e;
        e.addr = a; e.wr = w; e.data = d; e.hold = h;
        bus_q.push_back(e);
    endtask

    task automatic ps(input logic [31:0] i, input logic [31:0] c, input logic [31:0] d, input logic [7:0] g);
        step_t s;
        s.instr = i; s.cnt = c; s.dread = d; s.gap = g;
        step_q.push_back(s);
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while ((bus_q.size() != 0 || step_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(name, {32'(bus_q.size()), 32'(step_q.size())}, 192'd0);
    endtask

    // Monitor: pops an expectation on each bus completion and each enabled CPU cycle.
    initial begin
        int          hold, last_step, cyc;
        logic        unstable;
        logic [65:0] prev;
        logic [7:0]  gap;
        bus_t        e;
        step_t       s;
        hold = 0; last_step = -1; cyc = 0; unstable = 1'b0; prev = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset !== 1'b1) begin
                hold = 0; unstable = 1'b0; last_step = -1;
            end else begin
                if (bus_read || bus_write) begin
                    hold++;
                    if (hold > 1 && prev != {bus_address, bus_read, bus_write, bus_writedata}) unstable = 1'b1;
                    prev = {bus_address, bus_read, bus_write, bus_writedata};
                    if (!bus_waitrequest) begin
                        if (bus_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL bus_unexpected: addr %h wr %b, none expected", bus_address, bus_write);
                        end else begin
                            e = bus_q.pop_front();
                            chk("bus_xfer",
                                {bus_address, bus_write, bus_write ? bus_writedata : bus_readdata, 8'(hold),
                                 bus_byteenable, bus_read && bus_write, unstable},
                                {e.addr, e.wr, e.data, e.hold, 4'hF, 1'b0, 1'b0});
                        end
                        hold = 0; unstable = 1'b0;
                    end
                end else begin
                    hold = 0; unstable = 1'b0;
                end
                if (cpu_clk_enable) begin
                    gap = (last_step < 0) ? 8'd0 : 8'(cyc - last_step);
                    last_step = cyc;
                    if (step_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL step_unexpected: instr %h count %0d, none expected", instr_readdata, instr_count);
                    end else begin
                        s = step_q.pop_front();
                        chk("cpu_step", {instr_readdata, instr_count, data_readdata, gap},
                            {s.instr, s.cnt, s.dread, s.gap});
                    end
                end
            end
        end
    end

    function automatic logic [191:0] outs();
        return {cpu_clk_enable, instr_readdata, data_readdata, bus_address, bus_read, bus_write,
                bus_byteenable, bus_writedata, bus_error, instr_count};
    endfunction

    // Stimulus
    initial begin
        int n, rd, seen, post;
        pc_init = 32'd0;

        // Zero-wait program run, then halt with cpu_active low.
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 192'd0);
        pb(32'h0, 1'b0, 32'h2402_0005, 8'd1);
        pb(32'h4, 1'b0, 32'hAC02_0100, 8'd1);
        pb(32'h100, 1'b1, 32'd5, 8'd1);
        pb(32'h8, 1'b0, 32'h8C03_0100, 8'd1);
        pb(32'h100, 1'b0, 32'd5, 8'd1);
        pb(32'hC, 1'b0, 32'h0, 8'd1);
        ps(32'h2402_0005, 32'd0, 32'd0, 8'd0);
        ps(32'hAC02_0100, 32'd1, 32'd0, 8'd5);
        ps(32'h8C03_0100, 32'd2, 32'd5, 8'd5);
        ps(32'h0, 32'd3, 32'd5, 8'd4);
        reset = 1'b1;
        drain("drain_zero_wait", 200);
        repeat (2) @(negedge clk);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus_read || bus_write || cpu_clk_enable) seen++;
        end
        chk("halt_quiet", {32'(seen), instr_count}, {32'd0, 32'd4});

        // Same program with 3 wait cycles per transfer.
        reset = 1'b0; wait_n = 3; ram_clr = 1'b1; pc_init = 32'd0;
        repeat (3) @(negedge clk);
        pb(32'h0, 1'b0, 32'h2402_0005, 8'd4);
        pb(32'h4, 1'b0, 32'hAC02_0100, 8'd4);
        pb(32'h100, 1'b1, 32'd5, 8'd4);
        pb(32'h8, 1'b0, 32'h8C03_0100, 8'd4);
        pb(32'h100, 1'b0, 32'd5, 8'd4);
        pb(32'hC, 1'b0, 32'h0, 8'd4);
        ps(32'h2402_0005, 32'd0, 32'd0, 8'd0);
        ps(32'hAC02_0100, 32'd1, 32'd0, 8'd11);
        ps(32'h8C03_0100, 32'd2, 32'd5, 8'd11);
        ps(32'h0, 32'd3, 32'd5, 8'd7);
        reset = 1'b1;
        drain("drain_wait3", 400);

        // Read and write requested together -> error, bus goes quiet.
        reset = 1'b0; wait_n = 0; force_both = 1'b1;
        repeat (3) @(negedge clk);
        pb(32'h0, 1'b0, 32'h2402_0005, 8'd1);
        reset = 1'b1;
        rd = 0; post = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus_read || bus_write) rd++;
            if (bus_error && (bus_read || bus_write || cpu_clk_enable)) post++;
        end
        chk("both_strobes_error", {bus_error, 32'(rd), 32'(post), instr_count}, {1'b1, 32'd1, 32'd0, 32'd0});

        // Waitrequest stuck high: error after exactly 8 stalled fetch cycles.
        reset = 1'b0; force_both = 1'b0; stuck = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        rd = 0; n = 0;
        while (bus_error !== 1'b1 && n < 50) begin
            @(negedge clk);
            if (bus_read && !bus_error) rd++;
            n++;
        end
        repeat (3) @(negedge clk);
        chk("wait_timeout", {32'(rd), bus_error, bus_read}, {32'd8, 1'b1, 1'b0});
        stuck = 1'b0;

        // Store, then reset during a stalled load, then rerun from the load.
        reset = 1'b0; ram_clr = 1'b1; pc_init = 32'd4; stuck_rd = 1'b1;
        repeat (3) @(negedge clk);
        pb(32'h4, 1'b0, 32'hAC02_0100, 8'd1);
        pb(32'h100, 1'b1, 32'd5, 8'd1);
        pb(32'h8, 1'b0, 32'h8C03_0100, 8'd1);
        ps(32'hAC02_0100, 32'd0, 32'd0, 8'd0);
        reset = 1'b1;
        n = 0;
        while (!(bus_read === 1'b1 && bus_address == 32'h100) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_dread", {bus_read, bus_address, 32'(bus_q.size())}, {1'b1, 32'h100, 32'd0});
        repeat (2) @(negedge clk);
        ram_clr = 1'b0; pc_init = 32'd8; reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_mid_dread", outs(), 192'd0);
        stuck_rd = 1'b0;
        @(negedge clk);
        pb(32'h8, 1'b0, 32'h8C03_0100, 8'd1);
        pb(32'h100, 1'b0, 32'd5, 8'd1);
        pb(32'hC, 1'b0, 32'h0, 8'd1);
        ps(32'h8C03_0100, 32'd0, 32'd5, 8'd0);
        ps(32'h0, 32'd1, 32'd5, 8'd4);
        reset = 1'b1;
        drain("drain_restart", 200);
        repeat (3) @(negedge clk);
        chk("final_halt", {instr_count, bus_read, bus_error}, {32'd2, 1'b0, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_cpu_harvard_bus_bridge.md
Name: mips_cpu_harvard_bus_bridge

Overview:
- Responder for the Harvard CPU's instruction and data ports; initiator on a single shared memory bus with waitrequest.
- Lets the existing mips_cpu_harvard core run against bus-style memory with variable latency.
- Stalls the core through its clk_enable input, serialises each instruction fetch and optional data access onto the bus, then releases exactly one enabled CPU cycle per instruction.
- Sits between mips_cpu_harvard and the memory model, in both the testbench and the top level.

Parameters:
- WAIT_LIMIT, 1024: maximum consecutive waitrequest-high cycles per bus transfer before error. 0 disables the check.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset; resets the bridge when sampled 0 at a clk rising edge
- cpu_active  in  1  CPU active output
- cpu_clk_enable  out  1  drives CPU clk_enable
- instr_address  in  32  CPU fetch address
- instr_readdata  out  32  registered instruction word to CPU
- data_address  in  32  CPU data address
- data_read  in  1  CPU load request
- data_write  in  1  CPU store request
- data_writedata  in  32  CPU store data
- data_readdata  out  32  registered load data to CPU
- bus_address  out  32  bus address, CPU address passed unmodified
- bus_read  out  1  bus read strobe
- bus_write  out  1  bus write strobe
- bus_byteenable  out  4  constant 4'b1111 during transfers, 0 otherwise
- bus_writedata  out  32  registered store data
- bus_waitrequest  in  1  memory stall; transfer completes on the first cycle it is low while read/write is high
- bus_readdata  in  32  valid in the completing cycle
- bus_error  out  1  sticky error flag
- instr_count  out  32  number of STEP cycles since reset

Behaviour:
- Reset (reset==0 at edge):
  - State goes to IDLE.
  - All outputs are 0, including instr_readdata, data_readdata, instr_count and bus_error.
  - Any in-flight transfer is abandoned; strobes are low from the next cycle.
- States and transitions:
  - IDLE: next state is FETCH if cpu_active==1, else HALT.
  - FETCH: bus_read=1, bus_address=instr_address. On completion, latch bus_readdata into instr_readdata and go to SETTLE.
  - SETTLE: one cycle with no bus activity, so the CPU's combinational data_* outputs settle for the latched instruction.
    - data_read only: go to DREAD.
    - data_write only: register data_writedata into bus_writedata and go to DWRITE.
    - Neither: go to STEP.
    - Both high: go to ERROR.
  - DREAD: bus_read=1, bus_address=data_address. On completion, latch data_readdata and go to STEP.
  - DWRITE: bus_write=1, bus_address=data_address. On completion, go to STEP.
  - STEP: cpu_clk_enable=1 for exactly this one cycle; instr_count increments (wraps at 2^32-1 to 0). Next state is IDLE.
  - HALT: no bus activity, cpu_clk_enable=0. Stays in HALT until reset.
  - ERROR: bus_error=1, strobes and cpu_clk_enable low. Stays in ERROR until reset.
- Handshake rules:
  - bus_address, bus_read, bus_write and bus_writedata are held stable while bus_waitrequest==1.
  - bus_read and bus_write are never high together.
  - Strobes drop in the cycle after completion.
- Timeout: a per-transfer wait counter resets at each transfer start. When it reaches WAIT_LIMIT consecutive stalled cycles, the bridge goes to ERROR on that edge.
- cpu_clk_enable is 0 in every state except STEP.
- Latency with zero-wait memory:
  - Non-memory instruction: 4 cycles (IDLE, FETCH, SETTLE, STEP).
  - Load or store: 5 cycles.
  - Each waitrequest cycle adds 1.
- instr_readdata and data_readdata hold their last latched values outside the states that update them.
- A store data word outside a DWRITE state is never visible on the bus.

Test Plan:
- Zero-wait memory; program ADDIU $v0,$0,5 then JR $0 with a delay-slot NOP → cpu_clk_enable pulses once every 4 cycles; register_v0==5 at halt; instr_count==3; bus_error==0.
- Store then load via SW $v0,0x100($0) and LW $v1,0x100($0), with memory asserting waitrequest 3 cycles per transfer → the write cycle shows address 0x100, byteenable 4'b1111 and data held stable for 4 cycles; the load returns the stored value.
- Force data_read=data_write=1 during SETTLE → ERROR state, bus_error=1, no further bus strobes or cpu_clk_enable pulses.
- WAIT_LIMIT=8 with waitrequest stuck high → bus_error rises after exactly 8 stalled FETCH cycles; bus_read=0 afterwards.
- Assert reset=0 mid-DREAD with waitrequest high → bus_read=0 in the next cycle, all outputs 0, restart fetch at instr_address after reset=1.
- cpu_active=0 at IDLE → HALT; no bus_read for 20 further cycles; instr_count frozen.
